// File: rtl/axi_stream_length_unpack.sv
// Length-framed AXI-Stream unpacker.
// Each input frame is a header beat carrying a length field, followed by
// payload beats. The header is stripped, the payload is passed through with
// zero latency, and tlast is regenerated from the declared length. Frames
// whose input tlast disagrees with the declared length are flagged: a short
// frame is cut at the input tlast, and a long frame is cut at the declared
// length with the remaining input beats discarded up to the input tlast.
module axi_stream_length_unpack #(
  parameter int DSIZE = 32,
  parameter int LSIZE = 16,
  parameter int CSIZE = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  // framed input stream (header + payload)
  input  logic [DSIZE-1:0] axis_in_tdata,
  input  logic             axis_in_tvalid,
  input  logic             axis_in_tlast,
  output logic             axis_in_tready,
  // payload-only output stream
  output logic [DSIZE-1:0] axis_out_tdata,
  output logic             axis_out_tvalid,
  output logic             axis_out_tlast,
  input  logic             axis_out_tready,
  // status
  output logic             err_short,
  output logic             err_long,
  output logic [CSIZE-1:0] pkt_cnt,
  output logic [CSIZE-1:0] err_cnt
);

  typedef enum logic [1:0] {
    HEAD    = 2'd0,
    PAYLOAD = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LSIZE-1:0] len_reg;
  logic [LSIZE-1:0] len_nxt;
  logic [LSIZE-1:0] beat_cnt;
  logic [LSIZE-1:0] beat_nxt;
  logic             err_short_nxt;
  logic             err_long_nxt;
  logic             pkt_done;
  logic             at_len;
  logic             out_hs;

  // Payload data is a straight wire; tvalid/tlast gate whether it is visible.
  assign axis_out_tdata = axis_in_tdata;

  // The declared last beat is reached when the counter equals the latched
  // length; comparing before increment means len = all-ones never wraps.
  assign at_len = (beat_cnt == len_reg);
  assign out_hs = axis_out_tvalid && axis_out_tready;

  // Next-state, handshake steering and error/packet event decode.
  always_comb begin
    state_nxt       = state;
    len_nxt         = len_reg;
    beat_nxt        = beat_cnt;
    axis_in_tready  = 1'b0;
    axis_out_tvalid = 1'b0;
    axis_out_tlast  = 1'b0;
    err_short_nxt   = 1'b0;
    err_long_nxt    = 1'b0;
    pkt_done        = 1'b0;
    case (state)
      HEAD: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid) begin
          if (axis_in_tlast) begin
            // header with no payload behind it
            err_short_nxt = 1'b1;
          end else begin
            len_nxt   = axis_in_tdata[LSIZE-1:0];
            beat_nxt  = {LSIZE{1'b0}};
            state_nxt = PAYLOAD;
          end
        end else begin
          state_nxt = HEAD;
        end
      end
      PAYLOAD: begin
        axis_out_tvalid = axis_in_tvalid;
        axis_in_tready  = axis_out_tready;
        axis_out_tlast  = at_len || axis_in_tlast;
        if (out_hs) begin
          if (axis_in_tlast) begin
            // normal end, or short when the length was not yet reached
            pkt_done      = 1'b1;
            err_short_nxt = !at_len;
            state_nxt     = HEAD;
          end else if (at_len) begin
            // declared length exhausted but the input frame continues
            pkt_done     = 1'b1;
            err_long_nxt = 1'b1;
            state_nxt    = DRAIN;
          end else begin
            beat_nxt = beat_cnt + LSIZE'(1);
          end
        end else begin
          state_nxt = PAYLOAD;
        end
      end
      DRAIN: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid && axis_in_tlast) begin
          state_nxt = HEAD;
        end else begin
          state_nxt = DRAIN;
        end
      end
      default: begin
        state_nxt = HEAD;
      end
    endcase
  end

  // State, length and beat counter registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= HEAD;
      len_reg  <= {LSIZE{1'b0}};
      beat_cnt <= {LSIZE{1'b0}};
    end else begin
      state    <= state_nxt;
      len_reg  <= len_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Registered one-cycle error pulses and wrapping event counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      pkt_cnt   <= {CSIZE{1'b0}};
      err_cnt   <= {CSIZE{1'b0}};
    end else begin
      err_short <= err_short_nxt;
      err_long  <= err_long_nxt;
      if (pkt_done) begin
        pkt_cnt <= pkt_cnt + CSIZE'(1);
      end
      if (err_short_nxt || err_long_nxt) begin
        err_cnt <= err_cnt + CSIZE'(1);
      end
    end
  end

endmodule

// File: doc/axi_stream_length_unpack.md
AXI_STREAM_LENGTH_UNPACK -- requirements
Module: axi_stream_length_unpack

Interface
REQ-001 SHALL have parameter LSIZE, default 16: width of the length field carried in the header beat.
REQ-002 SHALL have parameter CSIZE, default 32: width of the packet counters.
REQ-003 SHALL take axis_in.aclk  input  1: the only clock, shared by axis_in and axis_out.
REQ-004 SHALL take axis_in.aresetn  input  1: asynchronous, active-low reset, shared by axis_in and axis_out.
REQ-005 SHALL expose axis_in  axi_stream_inf.slaver  DSIZE: framed input stream, consisting of a header beat followed by payload beats.
REQ-006 SHALL expose axis_out  axi_stream_inf.master  DSIZE: payload-only output stream with regenerated tlast.
REQ-007 SHALL output err_short  output  1: one-cycle pulse when input tlast arrives before the declared length.
REQ-008 SHALL output err_long  output  1: one-cycle pulse when the declared length ends before input tlast.
REQ-009 SHALL output pkt_cnt  output  CSIZE: count of output packets completed.
REQ-010 SHALL output err_cnt  output  CSIZE: count of err_short plus err_long events.
REQ-011 SHALL require axis_out.DSIZE == axis_in.DSIZE, with DSIZE >= LSIZE.

Function
REQ-012 SHALL use header format: len = axis_in.axis_tdata[LSIZE-1:0]; payload beats = len+1, so len==0 means 1 beat.
REQ-013 SHALL implement FSM states HEAD, PAYLOAD and DRAIN.
REQ-014 SHALL, in HEAD, drive axis_in.axis_tready=1 and axis_out.axis_tvalid=0; on an input handshake, latch len into len_reg, clear beat_cnt to 0, and go to PAYLOAD.
REQ-015 SHALL, in HEAD, treat a header beat with axis_in.axis_tlast=1 (no payload) as an error: pulse err_short, stay in HEAD, emit nothing.
REQ-016 SHALL, in PAYLOAD, pass data combinationally with zero latency and no bubbles: axis_out.axis_tvalid=axis_in.axis_tvalid, axis_in.axis_tready=axis_out.axis_tready, axis_out.axis_tdata=axis_in.axis_tdata.
REQ-017 SHALL increment beat_cnt (LSIZE bits) by 1 on each output handshake in PAYLOAD.
REQ-018 SHALL drive axis_out.axis_tlast = (state==PAYLOAD) && ((beat_cnt==len_reg) || axis_in.axis_tlast).
REQ-019 SHALL, on an output handshake with beat_cnt==len_reg and input tlast=1, end the packet normally: go to HEAD and increment pkt_cnt.
REQ-020 SHALL, on an output handshake with input tlast=1 and beat_cnt<len_reg, end the packet short: pulse err_short, increment pkt_cnt, go to HEAD.
REQ-021 SHALL, on an output handshake with beat_cnt==len_reg and input tlast=0, end the packet long: pulse err_long, increment pkt_cnt, go to DRAIN.
REQ-022 SHALL, in DRAIN, drive axis_in.axis_tready=1 and axis_out.axis_tvalid=0, discarding beats; on an input handshake with tlast=1, go to HEAD.
REQ-023 SHALL keep beat_cnt from wrapping: the maximum len of 2^LSIZE-1 yields 2^LSIZE beats, and last is detected before any wrap.
REQ-024 SHALL hold axis_out.axis_tvalid, tdata and tlast stable while axis_out.axis_tready=0, given a compliant upstream.
REQ-025 SHALL let err_cnt and pkt_cnt wrap modulo 2^CSIZE.
REQ-026 SHALL make err_short and err_long mutually exclusive in any cycle.

Reset
REQ-027 SHALL, on aresetn low, immediately force state=HEAD, beat_cnt=0, len_reg=0, pkt_cnt=0, err_cnt=0, err_short=0 and err_long=0.
REQ-028 SHALL, during reset, hold axis_out.axis_tvalid=0 and axis_out.axis_tlast=0.
REQ-029 SHALL, on reset asserted mid-packet, abandon the packet with no tlast emitted; after release, treat the next input beat as a header.

Verification
REQ-030 SHALL cover the normal case: header len=3 then 4 payload beats D0..D3 with tlast on D3 -> out D0..D3, tlast only on D3, pkt_cnt=1, no errors.
REQ-031 SHALL cover the single-beat case: header len=0 then 1 beat with tlast -> 1 output beat with tlast=1; and a header beat carrying tlast -> err_short pulse, no output, err_cnt=1.
REQ-032 SHALL cover the short case: header len=5, tlast on the 3rd payload beat -> 3 output beats, tlast on the 3rd, err_short pulse, then the next header is parsed correctly.
REQ-033 SHALL cover the long case: header len=1, tlast on the 4th payload beat -> 2 output beats, tlast on the 2nd, err_long pulse, beats 3-4 dropped, and axis_out.axis_tvalid=0 during DRAIN.
REQ-034 SHALL cover backpressure: random axis_out.axis_tready (50%) with len=255 -> 256 beats in order, data stable while stalled, and exactly one tlast.
REQ-035 SHALL cover reset mid-packet: assert aresetn low after 2 of 8 payload beats -> outputs and counters reach reset values at once, and after release a new len=0 packet outputs correctly.
